pattern_sequencer: RTL and testbench



---
 rtl/pattern_seq_pkg.sv | 36 +++
 rtl/pattern_seq_frame_counter.sv | 46 ++++
 rtl/pattern_sequencer.sv | 145 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared types, constants and step arithmetic for the pattern sequencer.
// Contents:
//   PATTERN_W, PATTERN_OFF : pattern-select width and the "off" (black) index
//   DWELL_W, BLANK_W       : dwell / blank counter widths
//   state_t + SHOW/PENDING/BLANK : FSM encoding (BLANK only reached when
//                                  PATTERN_SEQ_BLANK_EN is defined)
//   dir_e                  : step direction
//   pattern_step()         : next/prev index that wraps within 1..num-1, never hitting 0
package pattern_seq_pkg;

  localparam int unsigned PATTERN_W = 4;
  localparam logic [PATTERN_W-1:0] PATTERN_OFF = 4'd0;

  localparam int unsigned DWELL_W = 10;
  localparam int unsigned BLANK_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t SHOW    = 2'd0;
  localparam state_t PENDING = 2'd1;
  localparam state_t BLANK   = 2'd2;

  typedef enum logic {DIR_NEXT, DIR_PREV} dir_e;

  // Index 0 is "off" and is never a step result.
  function automatic logic [PATTERN_W-1:0] pattern_step(input logic [PATTERN_W-1:0] p,
                                                        input dir_e                 dir,
                                                        input int unsigned          num);
    logic [PATTERN_W-1:0] last;
    last = PATTERN_W'(num - 1);
    if (dir == DIR_NEXT) begin
      return (p == last) ? 4'd1 : p + 4'd1;
    end
    return (p == 4'd1) ? last : p - 4'd1;
  endfunction

endpackage

// File: rtl/pattern_seq_frame_counter.sv
// pattern_seq_frame_counter: loadable, enable-gated up/down counter used for frame counting.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (count resets to 0)
//   i_clear        : synchronous clear, highest priority
//   i_load         : load i_load_val
//   i_load_val     : value to load
//   i_en           : count one step (typically a frame strobe)
//   i_down         : 1 = decrement, 0 = increment
//   o_count        : current count
module pattern_seq_frame_counter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_en) begin
      count_d = i_down ? count_q - 1'b1 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: chooses the test pattern shown by the VGA pattern generator.
// Steps on next/prev pulses or automatically after DWELL_FRAMES frames; changes are applied
// only one clock after a frame strobe so no frame is torn.
// Optional feature macro: PATTERN_SEQ_BLANK_EN -- when defined, each transition shows
// BLANK_FRAMES black frames (pattern 0) before the new pattern.
// Ports:
//   i_clk, i_rst_n : pixel clock, asynchronous active-low reset
//   i_frame_strobe : one-cycle pulse at start of frame
//   i_next, i_prev : one-cycle step requests (both at once = ignored)
//   i_auto_en      : level, enables automatic cycling
//   o_pattern      : registered 4-bit pattern select
//   o_busy         : high while a transition is pending or blanking
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS  = 8,
  parameter int unsigned FIRST_PATTERN = 1,
  parameter int unsigned DWELL_FRAMES  = 120,
  parameter int unsigned BLANK_FRAMES  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame_strobe,
  input  logic                 i_next,
  input  logic                 i_prev,
  input  logic                 i_auto_en,
  output logic [PATTERN_W-1:0] o_pattern,
  output logic                 o_busy
);

  localparam logic [PATTERN_W-1:0] FIRST      = PATTERN_W'(FIRST_PATTERN);
  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [PATTERN_W-1:0] target_q, target_d;

  logic                 req_next, req_prev, manual_req;
  dir_e                 dir;
  logic                 in_show, auto_fire;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [PATTERN_W-1:0] target_acc;

  assign req_next   = i_next & ~i_prev;
  assign req_prev   = i_prev & ~i_next;
  assign manual_req = req_next | req_prev;
  // Auto expiry is an implicit "next", so prev only wins when explicitly requested.
  assign dir        = req_prev ? DIR_PREV : DIR_NEXT;
  assign in_show    = (state_q == SHOW);

  // A manual request in the same cycle suppresses expiry: only one step is taken.
  assign auto_fire = in_show & i_auto_en & i_frame_strobe & (dwell_cnt == DWELL_LAST) &
                     ~manual_req;

  // Counter is held at zero outside SHOW, which gives the clear-on-entry behaviour.
  pattern_seq_frame_counter #(
    .WIDTH(DWELL_W)
  ) u_dwell_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (~in_show | ~i_auto_en | manual_req | auto_fire),
    .i_load     (1'b0),
    .i_load_val ({DWELL_W{1'b0}}),
    .i_en       (in_show & i_auto_en & i_frame_strobe),
    .i_down     (1'b0),
    .o_count    (dwell_cnt)
  );

  // Presses while a transition is in flight accumulate onto the target.
  assign target_acc = manual_req ? pattern_step(target_q, dir, NUM_PATTERNS) : target_q;

`ifdef PATTERN_SEQ_BLANK_EN
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_FRAMES - 1);

  logic [BLANK_W-1:0] blank_cnt;

  pattern_seq_frame_counter #(
    .WIDTH(BLANK_W)
  ) u_blank_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (1'b0),
    .i_load     ((state_q == PENDING) & i_frame_strobe),
    .i_load_val (BLANK_LAST),
    .i_en       ((state_q == BLANK) & i_frame_strobe & (blank_cnt != '0)),
    .i_down     (1'b1),
    .o_count    (blank_cnt)
  );
`else
  logic [BLANK_W-1:0] unused_blank_frames;
  assign unused_blank_frames = BLANK_W'(BLANK_FRAMES);
`endif

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    target_d  = target_q;
    case (state_q)
      SHOW: begin
        if (manual_req | auto_fire) begin
          target_d = pattern_step(pattern_q, dir, NUM_PATTERNS);
          state_d  = PENDING;
        end
      end
      PENDING: begin
        target_d = target_acc;
        if (i_frame_strobe) begin
`ifdef PATTERN_SEQ_BLANK_EN
          pattern_d = PATTERN_OFF;
          state_d   = BLANK;
`else
          pattern_d = target_acc;
          state_d   = SHOW;
`endif
        end
      end
`ifdef PATTERN_SEQ_BLANK_EN
      BLANK: begin
        target_d = target_acc;
        if (i_frame_strobe && (blank_cnt == '0)) begin
          pattern_d = target_acc;
          state_d   = SHOW;
        end
      end
`endif
      default: state_d = SHOW;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SHOW;
      pattern_q <= FIRST;
      target_q  <= FIRST;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      target_q  <= target_d;
    end
  end

  assign o_pattern = pattern_q;
  assign o_busy    = ~in_show;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed + randomized bench for pattern_sequencer against a
// frame-level behavioural model. Follows PATTERN_SEQ_BLANK_EN the same way as the design.
module tb_pattern_sequencer;

  localparam int NUM   = 8;
  localparam int FIRST = 1;
  localparam int DWELL = 3;
  localparam int BLANK = 4;
  localparam int GAP   = 6;
`ifdef PATTERN_SEQ_BLANK_EN
  localparam int BLANK_MODEL = BLANK;
`else
  localparam int BLANK_MODEL = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_frame_strobe, i_next, i_prev, i_auto_en;
  logic [3:0] o_pattern;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: displayed pattern, pending target, transition flag, black frames left, dwell.
  int m_out, m_tgt, m_left, m_dwell;
  bit m_busy, m_blanking;

  always #5 i_clk = ~i_clk;

  pattern_sequencer #(
    .NUM_PATTERNS  (NUM),
    .FIRST_PATTERN (FIRST),
    .DWELL_FRAMES  (DWELL),
    .BLANK_FRAMES  (BLANK)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_frame_strobe (i_frame_strobe),
    .i_next         (i_next),
    .i_prev         (i_prev),
    .i_auto_en      (i_auto_en),
    .o_pattern      (o_pattern),
    .o_busy         (o_busy)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Valid patterns form a ring 1..NUM-1.
  function automatic int ring_step(input int p, input bit back);
    return back ? ((p + NUM - 3) % (NUM - 1)) + 1 : (p % (NUM - 1)) + 1;
  endfunction

  task automatic model_reset();
    m_out = FIRST; m_tgt = FIRST; m_busy = 0; m_blanking = 0; m_left = 0; m_dwell = 0;
  endtask

  task automatic model_step(input bit nx, input bit pv, input bit st, input bit au);
    bit rp, man, fire;
    rp   = pv && !nx;
    man  = (nx && !pv) || rp;
    fire = 0;
    if (!m_busy) begin
      if (man || !au) m_dwell = 0;
      else if (st) begin
        m_dwell++;
        if (m_dwell == DWELL) begin fire = 1; m_dwell = 0; end
      end
      if (man || fire) begin
        m_tgt  = ring_step(m_out, rp);
        m_busy = 1;
      end
    end else begin
      if (man) m_tgt = ring_step(m_tgt, rp);
      if (st) begin
        if (m_blanking) begin
          m_left--;
          if (m_left == 0) begin m_blanking = 0; m_busy = 0; m_out = m_tgt; end
        end else if (BLANK_MODEL > 0) begin
          m_blanking = 1; m_left = BLANK_MODEL; m_out = 0;
        end else begin
          m_busy = 0; m_out = m_tgt;
        end
      end
    end
  endtask

  // Check outputs against the model, then apply inputs for the coming edge.
  task automatic cycle(input bit nx, input bit pv, input bit st, input bit au);
    @(negedge i_clk);
    check("pattern", o_pattern, m_out);
    check("busy", o_busy, m_busy);
    i_next = nx; i_prev = pv; i_frame_strobe = st; i_auto_en = au;
    model_step(nx, pv, st, au);
  endtask

  task automatic frame(input bit au);
    cycle(0, 0, 1, au);
    repeat (GAP - 1) cycle(0, 0, 0, au);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (m_busy && n < 30) begin frame(0); n++; end
    if (m_busy) check("settle_timeout", 1, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic step_settle(input bit nx, input bit pv);
    cycle(nx, pv, 0, 0);
    cycle(0, 0, 0, 0);
    settle();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_pattern", o_pattern, FIRST);
    check("rst_busy", o_busy, 0);
    i_next = 0; i_prev = 0; i_frame_strobe = 0; i_auto_en = 0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_step(0, 0, 0, 0);
  endtask

  initial begin
    bit au;
    int r;
    i_rst_n = 1'b0; i_next = 0; i_prev = 0; i_frame_strobe = 0; i_auto_en = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check("reset_pattern", o_pattern, FIRST);
    check("reset_busy", o_busy, 0);
    i_rst_n = 1'b1;
    model_step(0, 0, 0, 0);

    // Idle for three frames: stays on the first pattern.
    repeat (3) frame(0);
    check("idle_pattern", o_pattern, 1);
    check("idle_busy", o_busy, 0);

    // Mid-frame next: busy the next cycle, lands on 2.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("busy_after_req", o_busy, 1);
    settle();
    check("next_to_2", o_pattern, 2);

    // Wrap in both directions, skipping 0.
    step_settle(0, 1);
    check("prev_to_1", o_pattern, 1);
    step_settle(0, 1);
    check("prev_wrap_7", o_pattern, 7);
    step_settle(1, 0);
    check("next_wrap_1", o_pattern, 1);

    // Reach 3, then one press plus three more after the first strobe.
    step_settle(1, 0);
    step_settle(1, 0);
    check("at_3", o_pattern, 3);
    cycle(1, 0, 0, 0);
    frame(0);
    repeat (3) begin cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); end
    settle();
    check("accumulate_7", o_pattern, 7);

    // Auto: two strobes, drop enable, re-raise; three more strobes needed.
    repeat (2) frame(1);
    check("auto_two", o_busy, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (2) frame(1);
    check("auto_hold", o_busy, 0);
    frame(1);
    check("auto_fire", o_busy, 1);
    repeat (12) frame(1);
    settle();

    // Simultaneous next and prev are ignored.
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("both_ignored", o_busy, 0);

    // Reset mid-transition.
    cycle(1, 0, 0, 0);
    frame(0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("busy_before_rst", o_busy, 1);
    do_reset();

    // Randomized traffic.
    au = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) au = ~au;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        au = 0;
      end else begin
        r = int'($urandom_range(0, 99));
        cycle((r < 5) || (r == 99), (r >= 5 && r < 10) || (r == 99),
              $urandom_range(0, 4) == 0, au);
      end
    end
    cycle(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
